// File: rtl/alu_sequencer.sv
// Issue/capture sequencer in front of the Neptune I ALU: one op per handshake, cleaned flags out.
// Optional sticky overflow trap enabled by defining ALU_SEQ_OFLOW_TRAP_EN.
module alu_sequencer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_opcode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             alu_en,
  output logic [4:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_d,
  input  logic             alu_o,
  input  logic             alu_cond,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_o,
  output logic             out_z,
  output logic             out_n,
  output logic             out_cond,
  output logic             out_illegal,
  output logic             trap,
  input  logic             trap_clr
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [4:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] data_q;
  logic             o_q, z_q, n_q, cond_q, illegal_q;

  logic accept;
  logic trap_block;
  logic is_arith, is_cmp, is_illegal;
  logic o_clean;

  assign is_arith   = (op_q >= 5'd3) && (op_q <= 5'd7);
  assign is_cmp     = (op_q >= 5'd8) && (op_q <= 5'd10);
  assign is_illegal = (op_q > 5'd20);
  // The ALU overflow mode is sticky across non-arithmetic ops, so mask it here.
  assign o_clean    = is_arith & alu_o;

  always_comb begin
    in_ready = ((state_q == IDLE) || ((state_q == DONE) && out_ready)) && !trap_block;
  end

  assign accept = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = CAPTURE;
      CAPTURE: state_d = DONE;
      DONE: begin
        if (out_ready) state_d = accept ? ISSUE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      data_q    <= '0;
      o_q       <= 1'b0;
      z_q       <= 1'b0;
      n_q       <= 1'b0;
      cond_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q <= in_opcode;
        a_q  <= in_a;
        b_q  <= in_b;
      end
      if (state_q == CAPTURE) begin
        data_q    <= alu_d;
        o_q       <= o_clean;
        // Zero is derived locally; the ALU zero flag also sees stale upper product bits.
        z_q       <= (alu_d == '0);
        n_q       <= alu_d[WIDTH-1];
        cond_q    <= is_cmp & alu_cond;
        illegal_q <= is_illegal;
      end
    end
  end

`ifdef ALU_SEQ_OFLOW_TRAP_EN
  logic trap_q;

  // Set has priority over clear when both land in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      trap_q <= 1'b0;
    end else if ((state_q == CAPTURE) && o_clean) begin
      trap_q <= 1'b1;
    end else if (trap_clr) begin
      trap_q <= 1'b0;
    end
  end

  assign trap       = trap_q;
  assign trap_block = trap_q;
`else
  logic unused_trap_clr;
  assign unused_trap_clr = trap_clr;
  assign trap            = 1'b0;
  assign trap_block      = 1'b0;
`endif

  assign alu_en      = (state_q == ISSUE);
  assign alu_opcode  = op_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;

  assign out_valid   = (state_q == DONE);
  assign out_data    = data_q;
  assign out_o       = o_q;
  assign out_z       = z_q;
  assign out_n       = n_q;
  assign out_cond    = cond_q;
  assign out_illegal = illegal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural Neptune I ALU stand-in
// whose overflow and cond flags are deliberately sticky.
module tb_alu_sequencer;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [4:0]   in_opcode = '0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         alu_en;
  logic [4:0]   alu_opcode;
  logic [W-1:0] alu_a, alu_b;
  logic [W-1:0] alu_d = '0;
  logic         alu_o = 1'b0;
  logic         alu_cond = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic         out_o, out_z, out_n, out_cond, out_illegal;
  logic         trap;
  logic         trap_clr = 1'b0;

  alu_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b),
    .alu_en(alu_en), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_d(alu_d), .alu_o(alu_o), .alu_cond(alu_cond),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_o(out_o), .out_z(out_z), .out_n(out_n), .out_cond(out_cond), .out_illegal(out_illegal),
    .trap(trap), .trap_clr(trap_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic        ov;
    logic        c;
  } raw_t;

  typedef struct packed {
    logic [15:0] data;
    logic [4:0]  flags;  // {o, z, n, cond, illegal}
  } exp_t;

  int   checks = 0;
  int   passed = 0;
  exp_t exp_q[$];
  int   rmode = 0;  // 0: out_ready=1, 1: random, 2: held 0, 3: manual

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  function automatic raw_t alu_raw(input logic [4:0] op, input logic [15:0] a,
                                   input logic [15:0] b);
    raw_t        r;
    logic [16:0] s;
    logic [31:0] p;
    r = '0;
    s = '0;
    p = '0;
    case (op)
      5'd0:  r.d = a;
      5'd1:  r.d = b;
      5'd2:  r.d = ~a;
      5'd3:  begin r.d = a - b; r.ov = (a[15] != b[15]) && (r.d[15] != a[15]); end
      5'd4:  begin s = {1'b0, a} + {1'b0, b}; r.d = s[15:0]; r.ov = s[16]; end
      5'd5:  begin r.d = a + b; r.ov = (a[15] == b[15]) && (r.d[15] != a[15]); end
      5'd6:  begin p = {16'b0, a} << b[3:0]; r.d = p[15:0]; r.ov = |p[31:16]; end
      5'd7:  begin p = {16'b0, a} * {16'b0, b}; r.d = p[15:0]; r.ov = |p[31:16]; end
      5'd8:  begin r.d = a - b; r.c = (a == b); end
      5'd9:  begin r.d = a - b; r.c = (a < b); end
      5'd10: begin r.d = a - b; r.c = ($signed(a) < $signed(b)); end
      5'd11: r.d = a | b;
      5'd12: r.d = a ^ b;
      5'd13: r.d = a & b;
      5'd14: r.d = a >> b[3:0];
      5'd15: r.d = ~(a & b);
      5'd16: r.d = ~(a | b);
      5'd17: r.d = a + 16'd1;
      5'd18: r.d = a - 16'd1;
      5'd19: r.d = {a[7:0], a[15:8]};
      5'd20: r.d = b - a;
      default: r.d = '0;
    endcase
    return r;
  endfunction

  // Registered ALU: overflow only updates on arithmetic ops, cond only on compares
  // (cleared on illegal ops), so stale flags are present for the DUT to filter.
  always @(posedge clk) begin
    raw_t r;
    if (rst) begin
      alu_d    <= '0;
      alu_o    <= 1'b0;
      alu_cond <= 1'b0;
    end else if (alu_en) begin
      r = alu_raw(alu_opcode, alu_a, alu_b);
      alu_d <= r.d;
      if (alu_opcode >= 5'd3 && alu_opcode <= 5'd7) alu_o <= r.ov;
      if (alu_opcode >= 5'd8 && alu_opcode <= 5'd10) alu_cond <= r.c;
      else if (alu_opcode > 5'd20) alu_cond <= 1'b0;
    end
  end

  function automatic exp_t expect_of(input logic [4:0] op, input logic [15:0] a,
                                     input logic [15:0] b);
    raw_t r;
    exp_t e;
    r = alu_raw(op, a, b);
    e.data  = r.d;
    e.flags = {(op >= 5'd3 && op <= 5'd7) ? r.ov : 1'b0,
               (r.d == 16'd0),
               r.d[15],
               (op >= 5'd8 && op <= 5'd10) ? r.c : 1'b0,
               (op > 5'd20)};
    return e;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      case (rmode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        2: out_ready = 1'b0;
        default: ;
      endcase
    end
  end

  // Monitor: pops the scoreboard on each output handshake and checks hold under backpressure.
  initial begin
    logic        stall;
    logic        prev_en;
    logic [20:0] held;
    exp_t        e;
    stall   = 1'b0;
    prev_en = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        stall   = 1'b0;
        prev_en = 1'b0;
        continue;
      end
      if (alu_en) check("alu_en_single_cycle", {31'b0, prev_en}, 32'd0);
      prev_en = alu_en;
      if (stall) begin
        check("hold_valid", {31'b0, out_valid}, 32'd1);
        check("hold_outputs", {11'b0, out_data, out_o, out_z, out_n, out_cond, out_illegal},
              {11'b0, held});
      end
      if (out_valid && out_ready) begin
        stall = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", {16'b0, out_data}, {16'b0, e.data});
          check("out_flags_ozncI", {27'b0, out_o, out_z, out_n, out_cond, out_illegal},
                {27'b0, e.flags});
        end
      end else if (out_valid) begin
        stall = 1'b1;
        held  = {out_data, out_o, out_z, out_n, out_cond, out_illegal};
      end else begin
        stall = 1'b0;
      end
    end
  end

  // Returns at posedge+1 of the accepting edge with in_valid dropped.
  task automatic send(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                      input bit push);
    int n;
    @(negedge clk);
    in_valid  = 1'b1;
    in_opcode = op;
    in_a      = a;
    in_b      = b;
    #1;
    n = 0;
    while (!in_ready && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end else begin
      if (push) exp_q.push_back(expect_of(op, a, b));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (exp_q.size() != 0 || out_valid) check("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    check({tag, "_alu_en"}, {31'b0, alu_en}, 32'd0);
    check({tag, "_alu_ports"}, {11'b0, alu_opcode, alu_a}, 32'd0);
    check({tag, "_alu_b"}, {16'b0, alu_b}, 32'd0);
    check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_out_data"}, {16'b0, out_data}, 32'd0);
    check({tag, "_out_flags"}, {26'b0, out_o, out_z, out_n, out_cond, out_illegal, trap}, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] corner [5];
    logic [15:0] ra, rb;
    corner[0] = 16'h0000; corner[1] = 16'h0001; corner[2] = 16'h7FFF;
    corner[3] = 16'h8000; corner[4] = 16'hFFFF;

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;

    // Add: alu_en exactly at accept+1, out_valid at accept+3.
    send(5'b00101, 16'd3, 16'd4, 1'b1);
    check("add_alu_en_t1", {31'b0, alu_en}, 32'd1);
    check("add_alu_a_b", {alu_a, alu_b}, {16'd3, 16'd4});
    @(posedge clk); #1;
    check("add_alu_en_t2", {31'b0, alu_en}, 32'd0);
    check("add_valid_t2", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check("add_valid_t3", {31'b0, out_valid}, 32'd1);
    wait_idle();

    // Sticky ALU overflow must not leak into a logic op.
    send(5'b00101, 16'h7FFF, 16'h0001, 1'b1);
    send(5'b01101, 16'hFFFF, 16'h0000, 1'b1);
    wait_idle();

    // Multiply overflow followed by compare.
    send(5'b00111, 16'h0100, 16'h0100, 1'b1);
    send(5'b01000, 16'd5, 16'd5, 1'b1);
    wait_idle();

    // Backpressure, then back-to-back accept in DONE.
    rmode = 3;
    out_ready = 1'b0;
    send(5'b01100, 16'h1234, 16'h00FF, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("bp_valid", {31'b0, out_valid}, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(5'b00100, 16'hFFFF, 16'h0002, 1'b1);
    check("b2b_alu_en", {31'b0, alu_en}, 32'd1);
    rmode = 0;
    wait_idle();

    // Illegal opcode, then reset while in ISSUE.
    send(5'b11111, 16'hABCD, 16'h1234, 1'b1);
    wait_idle();
    send(5'b00101, 16'd1, 16'd2, 1'b0);
    check("rst_issue_en", {31'b0, alu_en}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("midrst");
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      check("midrst_no_valid", {31'b0, out_valid}, 32'd0);
    end

    // Overflowing add and the trap.
    send(5'b00101, 16'h7FFF, 16'h0001, 1'b1);
    repeat (2) @(posedge clk);
    #1;
`ifdef ALU_SEQ_OFLOW_TRAP_EN
    check("trap_set", {31'b0, trap}, 32'd1);
    check("trap_blocks_done", {30'b0, out_valid, in_ready}, 32'd2);
    @(posedge clk); #1;
    check("trap_idle_blocked", {30'b0, trap, in_ready}, 32'd2);
    trap_clr = 1'b1;
    @(posedge clk); #1;
    trap_clr = 1'b0;
    check("trap_cleared", {30'b0, trap, in_ready}, 32'd1);
`else
    check("trap_tied_low", {31'b0, trap}, 32'd0);
    check("no_trap_in_ready", {30'b0, out_valid, in_ready}, 32'd3);
    trap_clr = 1'b1;
    @(posedge clk); #1;
    trap_clr = 1'b0;
    check("trap_clr_ignored", {31'b0, trap}, 32'd0);
`endif
    wait_idle();

    // Randomised traffic with random downstream backpressure.
    rmode    = 1;
    trap_clr = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 16'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(5'($urandom_range(0, 31)), ra, rb, 1'b1);
    end
    rmode = 0;
    wait_idle();
    trap_clr = 1'b0;
    check("queue_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Issue/capture sequencer directly upstream of the Neptune I ALU. Accepts one operation (opcode plus two operands) over a valid/ready handshake, drives the ALU enable, opcode and operand ports for exactly one cycle, and captures the registered ALU result and flags. It cleans the flags into per-operation values and presents them downstream on a second valid/ready handshake, so writeback never observes stale ALU state.

## Interface
- `WIDTH`, 16, datapath width; must equal the ALU width.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset. Shared with the ALU.
- `in_valid`  in  1  upstream operation valid.
- `in_ready`  out  1  sequencer can accept an operation this cycle.
- `in_opcode`  in  5  ALU opcode.
- `in_a`, `in_b`  in  WIDTH  operands A and B.
- `alu_en`  out  1  ALU enable.
- `alu_opcode`  out  5  ALU opcode.
- `alu_a`, `alu_b`  out  WIDTH  ALU operands.
- `alu_d`  in  WIDTH  ALU data output.
- `alu_o`, `alu_cond`  in  1  ALU overflow flag and conditional flag.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  WIDTH  result.
- `out_o`, `out_z`, `out_n`, `out_cond`, `out_illegal`  out  1  result flags.
- `trap`  out  1  sticky overflow trap. Active only under the macro (see Configuration).
- `trap_clr`  in  1  clears `trap`.

## Operation
- **FSM states:** IDLE, ISSUE, CAPTURE, DONE. Reset state is IDLE.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid`: latch opcode, A and B into the operation registers, then go to ISSUE.
- **ISSUE:**
  - `alu_en`=1 for this single cycle.
  - Always go to CAPTURE.
- **CAPTURE:**
  - Sample `alu_d`, `alu_o` and `alu_cond` into the result registers, then go to DONE.
- **DONE:**
  - `out_valid`=1; the result registers are held stable.
  - On `out_ready`, when `in_valid`=0: go to IDLE.
  - On `out_ready`, when `in_valid`=1: latch the new operation and go directly to ISSUE (back-to-back).
- **`in_ready` rule:** `in_ready` = (IDLE) | (DONE & `out_ready`).
- **ALU port drive:** `alu_opcode`, `alu_a` and `alu_b` are driven continuously from the operation registers; only `alu_en` is gated by state.
- **Flag cleanup, computed at CAPTURE from the latched opcode:**
  - `out_o` = `alu_o` for opcodes 00011–00111; otherwise 0. The ALU overflow mode is sticky across non-arithmetic ops and must not leak.
  - `out_z` = (`alu_d` == 0). Computed locally, because the ALU zero flag covers stale upper product bits.
  - `out_n` = `alu_d`[WIDTH-1].
  - `out_cond` = `alu_cond` for opcodes 01000–01010; otherwise 0.
  - `out_illegal` = 1 for opcodes > 10100. These are still issued: the ALU returns 0 and clears cond.
- **`out_data`:** equals `alu_d` exactly for all opcodes.

## Timing
- **Latency:** accept at edge T → `alu_en` high during cycle T+1 → `out_valid` high from cycle T+3.
- **Throughput:**
  - With `out_ready` held 1 and back-to-back input, one operation per 3 cycles.
  - Otherwise one operation per 4 cycles.
- **Reset values:**
  - State IDLE.
  - `in_ready`=1.
  - `alu_en`=0.
  - `alu_opcode`=0, `alu_a`=0, `alu_b`=0.
  - `out_valid`=0, `out_data`=0.
  - All `out_*` flags 0.
  - `trap`=0.
- **Reset mid-operation:** the operation is dropped, with no `out_valid`. The ALU resets in the same cycle.
- **Backpressure:** `out_*` signals must not change while `out_valid`=1 and `out_ready`=0.
- **Input ignore:** `in_valid` is ignored in ISSUE and CAPTURE.

## Configuration
- **Macro:** `ALU_SEQ_OFLOW_TRAP_EN`.
- **Defined:**
  - `trap` is set on the CAPTURE cycle whose cleaned `out_o`=1.
  - `trap` is cleared by `rst` or by `trap_clr`. Set wins if both occur in the same cycle.
  - While `trap`=1, `in_ready` is forced to 0; the pending DONE result still drains normally.
- **Undefined:** `trap` is tied to 0, `trap_clr` is ignored, and `in_ready` follows the base rule.

## Test plan
- **Add:** opcode 00101, A=3, B=4, `out_ready`=1 → `alu_en` high exactly 1 cycle; `out_valid` at accept+3 with data=7, o=0, z=0, n=0, cond=0.
- **Flag leak:** issue opcode 00101 with A=0x7FFF, B=1 (o=1, data=0x8000, n=1), then opcode 01101 with A=0xFFFF, B=0 → second result data=0, z=1, o=0.
- **Multiply then compare:** opcode 00111 with A=0x0100, B=0x0100 → data=0, z=1, o=1. Then opcode 01000 with A=5, B=5 → cond=1, o=0.
- **Backpressure and back-to-back:** hold `out_ready`=0 for 5 cycles → outputs stable. Then assert `out_ready` together with `in_valid` → next `alu_en` on the following cycle.
- **Illegal opcode and reset:** opcode 11111 → `out_illegal`=1, data=0. Assert `rst` during ISSUE → no `out_valid`; all outputs at reset values.
- **Trap (macro on):** overflowing add → `trap`=1 and `in_ready`=0 after DONE drains. Pulse `trap_clr` → `in_ready`=1.
